// File: rtl/ysyx_23060201_seq_ctrl.sv
// ysyx_23060201_seq_ctrl
// Multi-cycle sequencer for the single-issue NPC core. Owns the PC, walks each
// instruction through fetch, decode, execute, optional memory access and
// writeback, drives the instruction/data memory handshakes, gates the GPR
// write enable to the writeback cycle and counts retired instructions.
// All outputs are decoded from registers (Moore), except gpr_wen which passes
// the EXU enable through only while in writeback.
//
// Optional build macro: YSYX_23060201_SEQ_WATCHDOG_EN
//   When defined, a watchdog halts the core with halt_code 2 if a memory
//   request/response phase lasts TIMEOUT_CYCLES cycles.
module ysyx_23060201_seq_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  // IDU / EXU
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] dnpc,
  input  logic        exu_gpr_wen,
  input  logic        is_mem,
  input  logic        is_ebreak,
  // data memory
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  // register file / status
  output logic        gpr_wen,
  output logic [63:0] instret,
  output logic        halt,
  output logic [1:0]  halt_code
);

  localparam logic [1:0] HALT_EBREAK   = 2'd0;
  localparam logic [1:0] HALT_MISALIGN = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH_REQ  = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC       = 4'd4,
    S_MEM_REQ    = 4'd5,
    S_MEM_WAIT   = 4'd6,
    S_WB         = 4'd7,
    S_HALT       = 4'd8
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [63:0] instret_reg, instret_next;
  logic [1:0]  halt_code_reg, halt_code_next;

  // High when the watchdog has expired in a memory phase; constant 0 otherwise.
  logic        timeout;

`ifdef YSYX_23060201_SEQ_WATCHDOG_EN
  logic [31:0] wdog_reg, wdog_next;
  logic        wdog_active;
  logic        wdog_entry;

  // Counting covers every cycle spent requesting or waiting on either memory.
  assign wdog_active = (state_reg == S_FETCH_REQ)  || (state_reg == S_FETCH_WAIT) ||
                       (state_reg == S_MEM_REQ)    || (state_reg == S_MEM_WAIT);
  // Entering a request state starts a fresh measurement.
  assign wdog_entry  = (state_next != state_reg) &&
                       ((state_next == S_FETCH_REQ) || (state_next == S_MEM_REQ));
  assign timeout     = wdog_active && (wdog_reg >= TIMEOUT_CYCLES);

  // Watchdog next value: clear on entry, otherwise count while active.
  always_comb begin
    wdog_next = wdog_reg;
    if (wdog_entry) begin
      wdog_next = '0;
    end else if (wdog_active) begin
      wdog_next = wdog_reg + 32'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_reg <= '0;
    end else begin
      wdog_reg <= wdog_next;
    end
  end
`else
  // Without the watchdog the limit has no effect; fold it into a sink net.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // Next-state and datapath register updates for the instruction walk.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    inst_next      = inst_reg;
    instret_next   = instret_reg;
    halt_code_next = halt_code_reg;

    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH_REQ;
      end

      S_FETCH_REQ: begin
        if (timeout) begin
          state_next     = S_HALT;
          halt_code_next = HALT_TIMEOUT;
        end else if (imem_req_ready) begin
          state_next = S_FETCH_WAIT;
        end
      end

      S_FETCH_WAIT: begin
        if (timeout) begin
          state_next     = S_HALT;
          halt_code_next = HALT_TIMEOUT;
        end else if (imem_rsp_valid) begin
          inst_next  = imem_rdata;
          state_next = S_DECODE;
        end
      end

      // Gives the IDU/EXU combinational paths a full cycle to settle.
      S_DECODE: begin
        state_next = S_EXEC;
      end

      // ebreak outranks a misaligned target; neither retires.
      S_EXEC: begin
        if (is_ebreak) begin
          state_next     = S_HALT;
          halt_code_next = HALT_EBREAK;
        end else if (dnpc[1:0] != 2'b00) begin
          state_next     = S_HALT;
          halt_code_next = HALT_MISALIGN;
        end else if (is_mem) begin
          state_next = S_MEM_REQ;
        end else begin
          state_next = S_WB;
        end
      end

      S_MEM_REQ: begin
        if (timeout) begin
          state_next     = S_HALT;
          halt_code_next = HALT_TIMEOUT;
        end else if (lsu_req_ready) begin
          state_next = S_MEM_WAIT;
        end
      end

      S_MEM_WAIT: begin
        if (timeout) begin
          state_next     = S_HALT;
          halt_code_next = HALT_TIMEOUT;
        end else if (lsu_rsp_valid) begin
          state_next = S_WB;
        end
      end

      // Retire: commit the EXU next-PC and bump the counter (wraps naturally).
      S_WB: begin
        pc_next      = dnpc;
        instret_next = instret_reg + 64'd1;
        state_next   = S_FETCH_REQ;
      end

      // Absorbing: only reset leaves.
      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Sequencer state and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      pc_reg        <= RESET_PC;
      inst_reg      <= '0;
      instret_reg   <= '0;
      halt_code_reg <= HALT_EBREAK;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      inst_reg      <= inst_next;
      instret_reg   <= instret_next;
      halt_code_reg <= halt_code_next;
    end
  end

  // Requests are pure state decodes, so a valid holds until its ready is seen
  // and the fetch address (pc) cannot move while it is high.
  assign imem_req_valid = (state_reg == S_FETCH_REQ);
  assign imem_addr      = pc_reg;
  assign lsu_req_valid  = (state_reg == S_MEM_REQ);
  assign gpr_wen        = (state_reg == S_WB) && exu_gpr_wen;
  assign inst           = inst_reg;
  assign pc             = pc_reg;
  assign instret        = instret_reg;
  assign halt           = (state_reg == S_HALT);
  assign halt_code      = halt_code_reg;

endmodule

// File: tb/tb_ysyx_23060201_seq_ctrl.sv
// Directed, table-driven bench for ysyx_23060201_seq_ctrl. Each table row is
// one instruction: decode inputs, memory handshake delays and the expected
// cycle count, PC, instret and halt status. Multi-cycle corner cases (reset
// in MEM_WAIT with stray responses, watchdog) are hand-written sequences.
module tb_ysyx_23060201_seq_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] dnpc;
  logic        exu_gpr_wen;
  logic        is_mem;
  logic        is_ebreak;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic        gpr_wen;
  logic [63:0] instret;
  logic        halt;
  logic [1:0]  halt_code;

  ysyx_23060201_seq_ctrl #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .pc             (pc),
    .dnpc           (dnpc),
    .exu_gpr_wen    (exu_gpr_wen),
    .is_mem         (is_mem),
    .is_ebreak      (is_ebreak),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_rsp_valid  (lsu_rsp_valid),
    .gpr_wen        (gpr_wen),
    .instret        (instret),
    .halt           (halt),
    .halt_code      (halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          pre_rst;
    bit          mem;
    bit          ebreak;
    bit          wen;
    logic [31:0] off;
    int          iready;
    int          irsp;
    int          lready;
    int          lrsp;
    logic [31:0] instr;
    int          exp_cycles;
    bit          exp_halt;
    logic [1:0]  exp_code;
    logic [31:0] exp_pc;
    logic [63:0] exp_instret;
  } vec_t;

  int          n_vec;
  int          n_bad;
  logic [31:0] cur_pc;
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reset for two edges, check the reset state, release; returns in FETCH_REQ.
  task automatic do_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'hDEAD_BEEF;
    lsu_req_ready  = 1'b0;
    lsu_rsp_valid  = 1'b0;
    is_mem         = 1'b0;
    is_ebreak      = 1'b0;
    exu_gpr_wen    = 1'b1;
    dnpc           = RESET_PC + 32'd4;
    @(negedge clk);
    @(negedge clk);
    chk("rst_imem_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_lsu_req_valid",  64'(lsu_req_valid),  64'd0);
    chk("rst_gpr_wen",        64'(gpr_wen),        64'd0);
    chk("rst_halt",           64'(halt),           64'd0);
    chk("rst_halt_code",      64'(halt_code),      64'd0);
    chk("rst_pc",             64'(pc),             64'(RESET_PC));
    chk("rst_instret",        instret,             64'd0);
    chk("rst_inst",           64'(inst),           64'd0);
    rst         = 1'b0;
    exu_gpr_wen = 1'b0;
    @(negedge clk);
    cur_pc = RESET_PC;
  endtask

  // Execute one instruction starting at the current negedge (DUT in FETCH_REQ),
  // acting as both memories with the row's delays.
  task automatic run_inst(input int idx, input vec_t v);
    int          n, iv, lv, wen_cnt, wen_at, addr_bad, i_wcnt, l_wcnt, idle_bad;
    bit          i_acc, i_wait, l_acc, l_wait, done;
    logic [63:0] start_ir;
    logic [31:0] frz_pc;
    logic [63:0] frz_ir;
    n = 0; iv = 0; lv = 0; wen_cnt = 0; wen_at = 0; addr_bad = 0;
    i_wcnt = 0; l_wcnt = 0; idle_bad = 0;
    i_acc = 0; i_wait = 0; l_acc = 0; l_wait = 0; done = 0;
    if (v.pre_rst) do_reset();
    is_mem      = v.mem;
    is_ebreak   = v.ebreak;
    exu_gpr_wen = v.wen;
    dnpc        = cur_pc + v.off;
    start_ir    = instret;
    for (int k = 0; k < 100 && !done; k++) begin
      if (gpr_wen) begin wen_cnt++; wen_at = n + 1; end
      if (imem_req_valid) begin
        iv++;
        if (imem_addr !== cur_pc) addr_bad++;
      end
      if (lsu_req_valid) lv++;
      if (i_acc) begin i_wait = 1; i_wcnt = 0; i_acc = 0; end
      imem_rsp_valid = 1'b0;
      imem_rdata     = 32'hDEAD_BEEF;
      if (i_wait) begin
        if (i_wcnt == v.irsp) begin
          imem_rsp_valid = 1'b1; imem_rdata = v.instr; i_wait = 0;
        end else i_wcnt++;
      end
      imem_req_ready = 1'b0;
      if (imem_req_valid && iv > v.iready) begin imem_req_ready = 1'b1; i_acc = 1; end
      if (l_acc) begin l_wait = 1; l_wcnt = 0; l_acc = 0; end
      lsu_rsp_valid = 1'b0;
      if (l_wait) begin
        if (l_wcnt == v.lrsp) begin lsu_rsp_valid = 1'b1; l_wait = 0; end
        else l_wcnt++;
      end
      lsu_req_ready = 1'b0;
      if (lsu_req_valid && lv > v.lready) begin lsu_req_ready = 1'b1; l_acc = 1; end
      n++;
      @(negedge clk);
      if (halt || instret !== start_ir) done = 1;
    end
    if (!done) chk($sformatf("v%0d_budget", idx), 64'd0, 64'd1);
    chk($sformatf("v%0d_cycles", idx),   64'(n),         64'(v.exp_cycles));
    chk($sformatf("v%0d_pc", idx),       64'(pc),        64'(v.exp_pc));
    chk($sformatf("v%0d_instret", idx),  instret,        v.exp_instret);
    chk($sformatf("v%0d_halt", idx),     64'(halt),      64'(v.exp_halt));
    chk($sformatf("v%0d_halt_code", idx), 64'(halt_code), 64'(v.exp_code));
    chk($sformatf("v%0d_inst", idx),     64'(inst),      64'(v.instr));
    chk($sformatf("v%0d_imem_valid_cycles", idx), 64'(iv), 64'(v.iready + 1));
    chk($sformatf("v%0d_imem_addr_bad", idx), 64'(addr_bad), 64'd0);
    chk($sformatf("v%0d_lsu_valid_cycles", idx), 64'(lv),
        64'((v.mem && !v.exp_halt) ? v.lready + 1 : 0));
    chk($sformatf("v%0d_gpr_wen_count", idx), 64'(wen_cnt),
        64'((v.wen && !v.exp_halt) ? 1 : 0));
    if (v.wen && !v.exp_halt)
      chk($sformatf("v%0d_gpr_wen_cycle", idx), 64'(wen_at), 64'(v.exp_cycles));
    if (v.exp_halt) begin
      frz_pc = pc;
      frz_ir = instret;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (imem_req_valid || lsu_req_valid || gpr_wen || !halt) idle_bad++;
      end
      chk($sformatf("v%0d_halt_quiet", idx), 64'(idle_bad), 64'd0);
      chk($sformatf("v%0d_halt_pc_frozen", idx), 64'(pc), 64'(frz_pc));
      chk($sformatf("v%0d_halt_instret_frozen", idx), instret, frz_ir);
    end
    $display("vec %0d: cycles=%0d pc=%08h instret=%0d halt=%0b code=%0d gpr_wen_pulses=%0d",
             idx, n, pc, instret, halt, halt_code, wen_cnt);
    cur_pc = v.exp_pc;
  endtask

  initial begin
    vec_t rv;
    int   wd_n;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = '0;
    lsu_req_ready = 1'b0;  lsu_rsp_valid = 1'b0;
    is_mem = 1'b0; is_ebreak = 1'b0; exu_gpr_wen = 1'b0; dnpc = '0;
    cur_pc = RESET_PC;

    //           rst   mem   ebrk  wen   off             ir ir lr lr instr          cyc halt  code  exp_pc          instret
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd4,          0, 0, 0, 0, 32'h0010_0093, 5,  1'b0, 2'd0, 32'h8000_0004, 64'd1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd4,          3, 2, 0, 0, 32'h0000_0013, 10, 1'b0, 2'd0, 32'h8000_0008, 64'd2};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd4,          0, 0, 1, 2, 32'h0000_2083, 10, 1'b0, 2'd0, 32'h8000_000C, 64'd3};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd4,          0, 0, 0, 0, 32'h0010_2023, 7,  1'b0, 2'd0, 32'h8000_0010, 64'd4};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd4,          0, 0, 0, 0, 32'h0010_0073, 4,  1'b1, 2'd0, 32'h8000_0010, 64'd4};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd2,          0, 0, 0, 0, 32'h0020_006F, 4,  1'b1, 2'd1, 32'h8000_0000, 64'd0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd2,          0, 0, 0, 0, 32'h0010_0073, 4,  1'b1, 2'd0, 32'h8000_0000, 64'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 0, 1, 0, 0, 32'h0000_2103, 8,  1'b0, 2'd0, 32'h8000_0100, 64'd1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 0, 0, 0, 0, 32'hFF1F_F06F, 5,  1'b0, 2'd0, 32'h8000_00F0, 64'd2};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd1,          0, 0, 0, 0, 32'h0010_2183, 4,  1'b1, 2'd1, 32'h8000_00F0, 64'd2};

    for (int i = 0; i < 10; i++) run_inst(i, vecs[i]);

    // Reset while parked in MEM_WAIT, then stray responses from both memories.
    do_reset();
    is_mem = 1'b1; exu_gpr_wen = 1'b1; dnpc = RESET_PC + 32'd4;
    imem_req_ready = 1'b1;
    @(negedge clk);                        // FETCH_WAIT
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = 32'h0000_2003;
    @(negedge clk);                        // DECODE
    imem_rsp_valid = 1'b0;
    @(negedge clk);                        // EXEC
    @(negedge clk);                        // MEM_REQ
    chk("abort_mem_req_valid", 64'(lsu_req_valid), 64'd1);
    lsu_req_ready = 1'b1;
    @(negedge clk);                        // MEM_WAIT
    lsu_req_ready = 1'b0;
    chk("abort_mem_wait_valid", 64'(lsu_req_valid), 64'd0);
    @(negedge clk);                        // still MEM_WAIT
    chk("abort_mem_wait_gpr_wen", 64'(gpr_wen), 64'd0);
    rst = 1'b1;
    @(negedge clk);                        // IDLE
    chk("abort_idle_imem_valid", 64'(imem_req_valid), 64'd0);
    chk("abort_idle_pc", 64'(pc), 64'(RESET_PC));
    chk("abort_idle_instret", instret, 64'd0);
    rst = 1'b0; lsu_rsp_valid = 1'b1; imem_rsp_valid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    @(negedge clk);                        // FETCH_REQ, stray responses present
    chk("abort_fetch_req_valid", 64'(imem_req_valid), 64'd1);
    chk("abort_fetch_addr", 64'(imem_addr), 64'(RESET_PC));
    @(negedge clk);                        // still FETCH_REQ
    chk("abort_stray_gpr_wen", 64'(gpr_wen), 64'd0);
    chk("abort_stray_lsu_valid", 64'(lsu_req_valid), 64'd0);
    chk("abort_stray_inst", 64'(inst), 64'd0);
    chk("abort_stray_instret", instret, 64'd0);
    chk("abort_still_fetch_req", 64'(imem_req_valid), 64'd1);
    lsu_rsp_valid = 1'b0; imem_rsp_valid = 1'b0;
    cur_pc = RESET_PC;
    rv = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd4, 0, 0, 0, 0, 32'h0050_0113, 5, 1'b0, 2'd0, 32'h8000_0004, 64'd1};
    run_inst(10, rv);

    // Fetch accepted but never answered.
    do_reset();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
`ifdef YSYX_23060201_SEQ_WATCHDOG_EN
    wd_n = 0;
    while (!halt && wd_n < 40) begin
      @(negedge clk);
      wd_n++;
    end
    chk("watchdog_halt", 64'(halt), 64'd1);
    chk("watchdog_code", 64'(halt_code), 64'd2);
    $display("watchdog: halted after %0d wait cycles, code=%0d", wd_n, halt_code);
`else
    wd_n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (halt || imem_req_valid) wd_n++;
    end
    chk("no_watchdog_still_waiting", 64'(wd_n), 64'd0);
    chk("no_watchdog_halt_code", 64'(halt_code), 64'd0);
    $display("no watchdog: still waiting after 300 cycles, halt=%0b", halt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
